// File: rtl/video_timing_gen.sv
// Raster timing generator: two nested pixel/line counters plus registered
// data-enable, sync and frame-event outputs, all aligned to the same pixel.
// Parameters must keep H_TOTAL and V_TOTAL at or below 65535.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_de,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_frame_start,
  output logic        o_vblank_start,
  output logic [15:0] o_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

  // Sync output level for a position against a half-open [beg, fin) window.
  function automatic logic sync_level(input logic [15:0] pos,
                                      input logic [15:0] beg,
                                      input logic [15:0] fin);
    return ((pos >= beg) && (pos < fin)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [15:0] x_p0, y_p0;
  logic        de_p0, frame_p0, vblank_p0;

  logic [15:0] x_p1, y_p1, fc_p1;
  logic        de_p1, hs_p1, vs_p1, frame_p1, vblank_p1;

  // Stage p0: next raster position and the events it implies.
  always_comb begin
    x_p0 = x_p1 + 16'd1;
    y_p0 = y_p1;
    if (x_p1 == H_LAST) begin
      x_p0 = '0;
      y_p0 = (y_p1 == V_LAST) ? '0 : y_p1 + 16'd1;
    end
    de_p0     = (x_p0 < H_ACT) && (y_p0 < V_ACT);
    frame_p0  = (x_p0 == '0) && (y_p0 == '0);
    vblank_p0 = (x_p0 == '0) && (y_p0 == V_ACT);
  end

  // Stage p1: register position and derived outputs together so they never skew.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_p1      <= H_LAST;
      y_p1      <= V_LAST;
      de_p1     <= 1'b0;
      hs_p1     <= ~SYNC_POL;
      vs_p1     <= ~SYNC_POL;
      frame_p1  <= 1'b0;
      vblank_p1 <= 1'b0;
      fc_p1     <= 16'hFFFF;
    end else if (i_ce) begin
      x_p1      <= x_p0;
      y_p1      <= y_p0;
      de_p1     <= de_p0;
      hs_p1     <= sync_level(x_p0, HS_BEG, HS_END);
      vs_p1     <= sync_level(y_p0, VS_BEG, VS_END);
      frame_p1  <= frame_p0;
      vblank_p1 <= vblank_p0;
      if (frame_p0) fc_p1 <= fc_p1 + 16'd1;
    end else begin
      frame_p1  <= 1'b0;
      vblank_p1 <= 1'b0;
    end
  end

  assign o_x            = x_p1;
  assign o_y            = y_p1;
  assign o_de           = de_p1;
  assign o_h_sync       = hs_p1;
  assign o_v_sync       = vs_p1;
  assign o_frame_start  = frame_p1;
  assign o_vblank_start = vblank_p1;
  assign o_frame_count  = fc_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: full-size, small and 1x1 raster instances.
module tb_video_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] fc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        vbs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst0 = 1'b0, ce0 = 1'b0, rst1 = 1'b0, ce1 = 1'b0, rst2 = 1'b0, ce2 = 1'b0;
  logic [15:0] x0, y0, fc0, x1, y1, fc1, x2, y2, fc2;
  logic        de0, hs0, vs0, fs0, vb0, de1, hs1, vs1, fs1, vb1, de2, hs2, vs2, fs2, vb2;
  exp_t        obs0, obs1, obs2;
  exp_t        m0, m1, m2;
  exp_t        q0[$], q1[$], q2[$];

  assign obs0 = {x0, y0, fc0, de0, hs0, vs0, fs0, vb0};
  assign obs1 = {x1, y1, fc1, de1, hs1, vs1, fs1, vb1};
  assign obs2 = {x2, y2, fc2, de2, hs2, vs2, fs2, vb2};

  video_timing_gen dut0 (
    .i_clk(clk), .i_rst(rst0), .i_ce(ce0), .o_x(x0), .o_y(y0), .o_de(de0),
    .o_h_sync(hs0), .o_v_sync(vs0), .o_frame_start(fs0), .o_vblank_start(vb0),
    .o_frame_count(fc0));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_ce(ce1), .o_x(x1), .o_y(y1), .o_de(de1),
    .o_h_sync(hs1), .o_v_sync(vs1), .o_frame_start(fs1), .o_vblank_start(vb1),
    .o_frame_count(fc1));

  video_timing_gen #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
                     .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_POL(1'b1)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_ce(ce2), .o_x(x2), .o_y(y2), .o_de(de2),
    .o_h_sync(hs2), .o_v_sync(vs2), .o_frame_start(fs2), .o_vblank_start(vb2),
    .o_frame_count(fc2));

  // Reference raster model (active-high sync on all instances).
  function automatic exp_t model_next(exp_t c, bit r, bit ce_v, int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb);
    exp_t n;
    int ht, vt, nx, ny;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    n = c;
    if (r) begin
      n.x = 16'(ht - 1); n.y = 16'(vt - 1); n.fc = 16'hFFFF;
      n.de = 1'b0; n.hs = 1'b0; n.vs = 1'b0; n.fs = 1'b0; n.vbs = 1'b0;
    end else if (ce_v) begin
      if (int'(c.x) == ht - 1) begin
        nx = 0;
        ny = (int'(c.y) == vt - 1) ? 0 : int'(c.y) + 1;
      end else begin
        nx = int'(c.x) + 1;
        ny = int'(c.y);
      end
      n.x   = 16'(nx);
      n.y   = 16'(ny);
      n.de  = (nx < ha) && (ny < va);
      n.hs  = (nx >= ha + hf) && (nx < ha + hf + hsw);
      n.vs  = (ny >= va + vf) && (ny < va + vf + vsw);
      n.fs  = (nx == 0) && (ny == 0);
      n.vbs = (nx == 0) && (ny == va);
      if (n.fs) n.fc = c.fc + 16'd1;
    end else begin
      n.fs = 1'b0;
      n.vbs = 1'b0;
    end
    return n;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("(%0d,%0d) fc=%h de=%b hs=%b vs=%b fs=%b vb=%b",
                     e.x, e.y, e.fc, e.de, e.hs, e.vs, e.fs, e.vbs);
  endfunction

  // Drive one cycle on instance d, push the expected result, sample #1 after the edge.
  task automatic drive(input int d, input bit r, input bit c);
    case (d)
      0: begin rst0 = r; ce0 = c; m0 = model_next(m0, r, c, 1280, 110, 40, 220, 720, 5, 5, 20); q0.push_back(m0); end
      1: begin rst1 = r; ce1 = c; m1 = model_next(m1, r, c, 4, 1, 1, 1, 2, 1, 1, 1); q1.push_back(m1); end
      default: begin rst2 = r; ce2 = c; m2 = model_next(m2, r, c, 1, 0, 0, 0, 1, 0, 0, 0); q2.push_back(m2); end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (3) begin
      drive(0, 1'b1, 1'b1);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin failures++; $display("FAIL reset_hold got %s want %s", fmt(obs0), fmt(e)); end
    end
    checks++;
    if (x0 !== 16'd1649 || y0 !== 16'd749 || fc0 !== 16'hFFFF || de0 !== 1'b0 ||
        hs0 !== 1'b0 || vs0 !== 1'b0 || fs0 !== 1'b0 || vb0 !== 1'b0) begin
      failures++; $display("FAIL reset_values got %s want (1649,749) fc=ffff all low", fmt(obs0));
    end
    drive(0, 1'b0, 1'b1);
    e = q0.pop_front();
    checks++;
    if (obs0 !== e) begin failures++; $display("FAIL first_adv got %s want %s", fmt(obs0), fmt(e)); end
    checks++;
    if (x0 !== 16'd0 || y0 !== 16'd0 || de0 !== 1'b1 || fs0 !== 1'b1 || fc0 !== 16'd0) begin
      failures++; $display("FAIL first_frame got %s want (0,0) de=1 fs=1 fc=0000", fmt(obs0));
    end
    drive(0, 1'b0, 1'b0);
    e = q0.pop_front();
    checks++;
    if (fs0 !== 1'b0 || x0 !== 16'd0 || fc0 !== 16'd0 || obs0 !== e) begin
      failures++; $display("FAIL fs_one_clock got %s want %s", fmt(obs0), fmt(e));
    end
  endtask

  task automatic test_hsync();
    exp_t e;
    int hs_cnt = 0;
    int de_cnt = int'(de0);
    for (int i = 0; i < 1650; i++) begin
      drive(0, 1'b0, 1'b1);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin failures++; $display("FAIL hline got %s want %s", fmt(obs0), fmt(e)); end
      if (y0 == 16'd0) begin hs_cnt += int'(hs0); de_cnt += int'(de0); end
      if (x0 == 16'd1280) begin
        checks++;
        if (de0 !== 1'b0) begin failures++; $display("FAIL de_edge got de=%b want 0 at x=1280", de0); end
      end
    end
    checks++;
    if (hs_cnt != 40) begin failures++; $display("FAIL hsync_width got %0d want 40", hs_cnt); end
    checks++;
    if (de_cnt != 1280) begin failures++; $display("FAIL de_width got %0d want 1280", de_cnt); end
    checks++;
    if (x0 !== 16'd0 || y0 !== 16'd1) begin failures++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", x0, y0); end
  endtask

  task automatic test_clock_enable();
    exp_t e;
    bit ce_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] want_x[4] = '{16'd101, 16'd101, 16'd101, 16'd102};
    repeat (100) begin
      drive(0, 1'b0, 1'b1);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin failures++; $display("FAIL ce_run got %s want %s", fmt(obs0), fmt(e)); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, ce_seq[i]);
      e = q0.pop_front();
      checks++;
      if (x0 !== want_x[i] || y0 !== 16'd1 || fs0 !== 1'b0 || obs0 !== e) begin
        failures++; $display("FAIL ce_hold step %0d got %s want %s", i, fmt(obs0), fmt(e));
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    repeat (538) begin
      drive(0, 1'b0, 1'b1);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin failures++; $display("FAIL to_mid got %s want %s", fmt(obs0), fmt(e)); end
    end
    checks++;
    if (x0 !== 16'd640 || y0 !== 16'd1 || de0 !== 1'b1) begin
      failures++; $display("FAIL mid_pos got (%0d,%0d) de=%b want (640,1) de=1", x0, y0, de0);
    end
    drive(0, 1'b1, 1'b1);
    e = q0.pop_front();
    checks++;
    if (x0 !== 16'd1649 || y0 !== 16'd749 || fc0 !== 16'hFFFF || de0 !== 1'b0 || fs0 !== 1'b0 || obs0 !== e) begin
      failures++; $display("FAIL mid_reset got %s want %s", fmt(obs0), fmt(e));
    end
    drive(0, 1'b0, 1'b1);
    e = q0.pop_front();
    checks++;
    if (x0 !== 16'd0 || y0 !== 16'd0 || fs0 !== 1'b1 || fc0 !== 16'd0 || obs0 !== e) begin
      failures++; $display("FAIL mid_restart got %s want %s", fmt(obs0), fmt(e));
    end
  endtask

  task automatic test_vertical();
    exp_t e;
    int vs_cnt = 0, hs_cnt = 0, de_cnt = 0, vb_cnt = 0, fs_cnt = 0;
    drive(1, 1'b1, 1'b1); void'(q1.pop_front());
    drive(1, 1'b1, 1'b1); void'(q1.pop_front());
    drive(1, 1'b0, 1'b1);
    e = q1.pop_front();
    checks++;
    if (x1 !== 16'd0 || y1 !== 16'd0 || fs1 !== 1'b1 || fc1 !== 16'd0 || obs1 !== e) begin
      failures++; $display("FAIL small_start got %s want %s", fmt(obs1), fmt(e));
    end
    repeat (35) begin
      drive(1, 1'b0, 1'b1);
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin failures++; $display("FAIL small_frame got %s want %s", fmt(obs1), fmt(e)); end
      vs_cnt += int'(vs1); hs_cnt += int'(hs1); de_cnt += int'(de1);
      vb_cnt += int'(vb1); fs_cnt += int'(fs1);
      if (vb1 === 1'b1) begin
        checks++;
        if (x1 !== 16'd0 || y1 !== 16'd2) begin failures++; $display("FAIL vblank_pos got (%0d,%0d) want (0,2)", x1, y1); end
      end
    end
    checks++;
    if (vs_cnt != 7 || hs_cnt != 5 || de_cnt != 8 || vb_cnt != 1 || fs_cnt != 1 || fc1 !== 16'd1) begin
      failures++;
      $display("FAIL small_counts got vs=%0d hs=%0d de=%0d vb=%0d fs=%0d fc=%0d want 7 5 8 1 1 1",
               vs_cnt, hs_cnt, de_cnt, vb_cnt, fs_cnt, fc1);
    end
  endtask

  task automatic test_small_random();
    exp_t e;
    bit r, c;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 3) != 0);
      drive(1, r, c);
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin failures++; $display("FAIL small_rand cyc %0d got %s want %s", i, fmt(obs1), fmt(e)); end
    end
  endtask

  task automatic test_count_wrap();
    exp_t e;
    drive(2, 1'b1, 1'b1);
    e = q2.pop_front();
    checks++;
    if (fc2 !== 16'hFFFF || obs2 !== e) begin failures++; $display("FAIL wrap_reset got %s want %s", fmt(obs2), fmt(e)); end
    for (int i = 0; i < 65536; i++) begin
      drive(2, 1'b0, 1'b1);
      e = q2.pop_front();
      checks++;
      if (obs2 !== e) begin failures++; $display("FAIL wrap_run adv %0d got %s want %s", i, fmt(obs2), fmt(e)); end
    end
    checks++;
    if (fc2 !== 16'hFFFF) begin failures++; $display("FAIL wrap_top got %h want ffff", fc2); end
    drive(2, 1'b0, 1'b1);
    e = q2.pop_front();
    checks++;
    if (fc2 !== 16'h0000 || fs2 !== 1'b1 || obs2 !== e) begin
      failures++; $display("FAIL wrap_zero got %s want %s", fmt(obs2), fmt(e));
    end
  endtask

  initial begin
    m0 = '0; m1 = '0; m2 = '0;
    test_reset();
    test_hsync();
    test_clock_enable();
    test_mid_reset();
    test_vertical();
    test_small_random();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
